// File: rtl/fft_pkg.sv
// Shared types and sizes for the FFT core.
// Frame length is 2**FFT_N complex points of 2*FFT_BIT_WIDTH bits.
package fft_pkg;

  localparam int FFT_BIT_WIDTH = 16;
  localparam int FFT_N         = 9;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } loader_state_t;

  typedef logic [2*FFT_BIT_WIDTH-1:0] cplx_word_t;

endpackage

// File: rtl/fft_loader_sample_pair_avg.sv
// 2:1 decimator used by fft_loader when DECIM2_EN is defined.
// Holds the first sample of a pair; the second emits floor((a+b)/2).
module sample_pair_avg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         half_q, half_d;
  logic [W-1:0] hold_q, hold_d;
  logic [W:0]   sum;

  always_comb begin
    half_d = half_q;
    hold_d = hold_q;
    if (clr) begin
      half_d = 1'b0;
    end else if (in_valid) begin
      half_d = ~half_q;
      if (!half_q) hold_d = in_data;
    end
  end

  // Sign-extend one bit so the sum cannot overflow before the shift.
  assign sum       = {hold_q[W-1], hold_q} + {in_data[W-1], in_data};
  assign out_data  = sum[W:1];
  assign out_valid = in_valid & half_q & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q <= 1'b0;
      hold_q <= '0;
    end else begin
      half_q <= half_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/fft_loader.sv
// Input-side load stage of the FFT core: sample stream -> RAM0 writes.
// Optional DECIM2_EN inserts a 2:1 pair-averaging decimator.
module fft_loader
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH = FFT_BIT_WIDTH,
  parameter int N         = FFT_N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [BIT_WIDTH-1:0]   sample_data,
  output logic                   sample_ready,
  input  logic                   fft_done,
  output logic                   fft_load,
  output logic [N-1:0]           add_rd,
  output logic [2*BIT_WIDTH-1:0] wd,
  output logic                   fft_start,
  output logic                   busy,
  output logic [7:0]             frame_cnt
);

  loader_state_t state_q, state_d;

  logic [N-1:0]           cnt_q, cnt_d;
  logic                   fft_load_q, fft_load_d;
  logic [N-1:0]           add_rd_q, add_rd_d;
  logic [2*BIT_WIDTH-1:0] wd_q, wd_d;
  logic                   fft_start_q, fft_start_d;
  logic                   busy_q, busy_d;
  logic [7:0]             frame_q, frame_d;

  logic                   accept;
  logic                   wr_vld;
  logic [BIT_WIDTH-1:0]   wr_dat;

  assign sample_ready = (state_q == LOAD);
  assign accept       = sample_valid & sample_ready;

`ifdef DECIM2_EN
  sample_pair_avg #(
    .W (BIT_WIDTH)
  ) u_avg (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (state_q == START),
    .in_valid  (accept),
    .in_data   (sample_data),
    .out_valid (wr_vld),
    .out_data  (wr_dat)
  );
`else
  assign wr_vld = accept;
  assign wr_dat = sample_data;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    add_rd_d    = add_rd_q;
    wd_d        = wd_q;
    fft_load_d  = wr_vld;
    fft_start_d = (state_q == START);
    if (wr_vld) begin
      add_rd_d = cnt_q;
      wd_d     = {wr_dat, {BIT_WIDTH{1'b0}}};
    end
    unique case (state_q)
      LOAD: begin
        if (wr_vld) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {N{1'b1}}) state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (fft_done) begin
          frame_d = frame_q + 8'd1;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
    busy_d = (state_d != LOAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      fft_load_q  <= 1'b0;
      add_rd_q    <= '0;
      wd_q        <= '0;
      fft_start_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fft_load_q  <= fft_load_d;
      add_rd_q    <= add_rd_d;
      wd_q        <= wd_d;
      fft_start_q <= fft_start_d;
      busy_q      <= busy_d;
      frame_q     <= frame_d;
    end
  end

  assign fft_load  = fft_load_q;
  assign add_rd    = add_rd_q;
  assign wd        = wd_q;
  assign fft_start = fft_start_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_fft_loader.sv
// Scoreboard bench for fft_loader; writes are matched in order.
// With DECIM2_EN defined only the reset and decimator scenarios run.
module tb_fft_loader;
  import fft_pkg::*;

  localparam int W     = FFT_BIT_WIDTH;
  localparam int NA    = FFT_N;
  localparam int FRAME = 1 << NA;

  logic           clk = 1'b0;
  logic           reset;
  logic           sample_valid;
  logic [W-1:0]   sample_data;
  logic           sample_ready;
  logic           fft_done;
  logic           fft_load;
  logic [NA-1:0]  add_rd;
  logic [2*W-1:0] wd;
  logic           fft_start;
  logic           busy;
  logic [7:0]     frame_cnt;

  fft_loader dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .fft_done     (fft_done),
    .fft_load     (fft_load),
    .add_rd       (add_rd),
    .wd           (wd),
    .fft_start    (fft_start),
    .busy         (busy),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NA-1:0] addr;
    cplx_word_t    data;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            start_cnt, start_cyc;
  int            load_cnt, first_load, last_load;
  int            accepts, acc_cyc;
  logic [NA-1:0] exp_addr;
  bit            half;
  logic [W-1:0]  held;

  always @(posedge clk) cyc <= cyc + 1;

  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (fft_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (fft_load === 1'b1) begin
      if (load_cnt == 0) first_load = cyc;
      last_load = cyc;
      load_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write add_rd=%0d wd=%h (no accept pending)",
                 add_rd, wd);
      end else begin
        e = sb.pop_front();
        if (add_rd !== e.addr || wd !== e.data) begin
          errors++;
          $display("FAIL sb_write add_rd=%0d wd=%h expected add_rd=%0d wd=%h",
                   add_rd, wd, e.addr, e.data);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d);
    exp_t x;
    int   sum;
    @(negedge clk);
    sample_valid = v;
    sample_data  = d;
    if (v && sample_ready === 1'b1) begin
      accepts++;
      acc_cyc = cyc;
`ifdef DECIM2_EN
      if (half) begin
        sum    = int'($signed(held)) + int'($signed(d));
        x.addr = exp_addr;
        x.data = {W'(sum >>> 1), {W{1'b0}}};
        sb.push_back(x);
        exp_addr++;
      end else begin
        held = d;
      end
      half = ~half;
`else
      x.addr = exp_addr;
      x.data = {d, {W{1'b0}}};
      sb.push_back(x);
      exp_addr++;
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0);
  endtask

  task automatic clear_model();
    sb.delete();
    exp_addr  = '0;
    accepts   = 0;
    half      = 1'b0;
    start_cnt = 0;
    load_cnt  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b0;
    sample_valid = 1'b0;
    fft_done     = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    clear_model();
  endtask

  task automatic pulse_done();
    @(negedge clk);
    sample_valid = 1'b0;
    fft_done     = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [NA+2*W+11:0] got, want;
    want = {1'b0, {NA{1'b0}}, {2*W{1'b0}}, 1'b0, 1'b0, 8'd0, 1'b1};
    reset = 1'b0;
    repeat (2) @(negedge clk);
    got = {fft_load, add_rd, wd, fft_start, busy, frame_cnt, sample_ready};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_state got %h expected %h", got, want);
    end
    reset = 1'b1;
    clear_model();
    for (int i = 0; i < 100; i++) drive(1'b1, W'(16'h0100 + i));
    @(negedge clk);
    sample_valid = 1'b0;
    reset        = 1'b0;
    #1;
    got = {fft_load, add_rd, wd, fft_start, busy, frame_cnt, sample_ready};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_mid_frame got %h expected %h", got, want);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    drive(1'b1, W'(16'h1234));
    idle(2);
    checks++;
    if (load_cnt !== 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL reset_first_write writes=%0d pending=%0d expected 1 and 0",
               load_cnt, sb.size());
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < FRAME; i++) drive(1'b1, W'($urandom));
    idle(4);
    checks++;
    if (load_cnt != FRAME || last_load - first_load != FRAME - 1) begin
      errors++;
      $display("FAIL stream_writes count=%0d span=%0d expected %0d and %0d",
               load_cnt, last_load - first_load, FRAME, FRAME - 1);
    end
    checks++;
    if (start_cnt != 1) begin
      errors++;
      $display("FAIL stream_start_count got %0d expected 1", start_cnt);
    end
    checks++;
    if (start_cyc - acc_cyc != 2) begin
      errors++;
      $display("FAIL stream_start_latency got %0d expected 2", start_cyc - acc_cyc);
    end
    checks++;
    if ({busy, sample_ready} !== 2'b10 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_wait busy/ready=%b pending=%0d expected 10 and 0",
               {busy, sample_ready}, sb.size());
    end
  endtask

  task automatic test_wait_hold();
    int l0;
    bit ready_seen;
    l0         = load_cnt;
    ready_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, W'(i));
      if (sample_ready !== 1'b0) ready_seen = 1'b1;
    end
    checks++;
    if (ready_seen || load_cnt != l0 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wait_hold ready_seen=%0d writes=%0d frame_cnt=%0d expected 0 %0d 0",
               ready_seen, load_cnt - l0, frame_cnt, 0);
    end
    pulse_done();
    checks++;
    if (frame_cnt !== 8'd1 || {sample_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL wait_done frame_cnt=%0d ready/busy=%b expected 1 and 10",
               frame_cnt, {sample_ready, busy});
    end
  endtask

  task automatic test_done_in_load();
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, W'(16'h0A00 + i));
    pulse_done();
    checks++;
    if (frame_cnt !== 8'd0 || {sample_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL done_in_load frame_cnt=%0d ready/busy=%b expected 0 and 10",
               frame_cnt, {sample_ready, busy});
    end
    for (int i = 0; i < 5; i++) drive(1'b1, W'(16'h0B00 + i));
    idle(2);
    checks++;
    if (load_cnt != 15 || sb.size() != 0) begin
      errors++;
      $display("FAIL done_in_load_writes count=%0d pending=%0d expected 15 and 0",
               load_cnt, sb.size());
    end
  endtask

  task automatic test_random_gaps();
    int iter;
    do_reset();
    iter = 0;
    while (accepts < FRAME && iter < 4000) begin
      drive($urandom_range(0, 9) >= 3, W'($urandom));
      iter++;
    end
    checks++;
    if (accepts != FRAME) begin
      errors++;
      $display("FAIL gaps_timeout accepts=%0d expected %0d", accepts, FRAME);
    end
    idle(4);
    checks++;
    if (load_cnt != FRAME || start_cnt != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL gaps_frame writes=%0d starts=%0d pending=%0d expected %0d 1 0",
               load_cnt, start_cnt, sb.size(), FRAME);
    end
    pulse_done();
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL gaps_frame_cnt got %0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < FRAME; i++) drive(1'b1, W'(FRAME - i));
    idle(4);
    checks++;
    if (load_cnt != 2 * FRAME || start_cnt != 2 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_frame writes=%0d starts=%0d pending=%0d expected %0d 2 0",
               load_cnt, start_cnt, sb.size(), 2 * FRAME);
    end
    pulse_done();
    checks++;
    if (frame_cnt !== 8'd2) begin
      errors++;
      $display("FAIL b2b_frame_cnt got %0d expected 2", frame_cnt);
    end
  endtask

  task automatic test_decim();
    do_reset();
    drive(1'b1, W'(16'h7FFF));
    drive(1'b1, W'(16'h7FFF));
    drive(1'b1, W'(-3));
    drive(1'b1, W'(0));
    idle(2);
    checks++;
    if (load_cnt != 2 || sb.size() != 0) begin
      errors++;
      $display("FAIL decim_pairs writes=%0d pending=%0d expected 2 and 0",
               load_cnt, sb.size());
    end
    while (accepts < 2 * FRAME) drive(1'b1, W'($urandom));
    idle(4);
    checks++;
    if (load_cnt != FRAME || start_cnt != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL decim_frame writes=%0d starts=%0d pending=%0d expected %0d 1 0",
               load_cnt, start_cnt, sb.size(), FRAME);
    end
  endtask

  initial begin
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    fft_done     = 1'b0;
    clear_model();
    test_reset();
`ifdef DECIM2_EN
    test_decim();
`else
    test_stream();
    test_wait_hold();
    test_done_in_load();
    test_random_gaps();
    test_back_to_back();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
